// File: rtl/nlms_mem_arbiter.sv
// Two-requester burst arbiter for the NLMS shared single-port RAM (m0 = AXI slave, m1 = filter core).
// Optional watchdog release: define NLMS_ARB_TIMEOUT_EN (limit TMO_CYC cycles).
module nlms_mem_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 64
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_last,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_last,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_err
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t            state, nxt;
  logic              prio, prio_nxt;
  logic              acc0, acc1, rel, tmo;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  assign acc0   = m0_req & m0_gnt;
  assign acc1   = m1_req & m1_gnt;
  assign mem_en = acc0 | acc1;
  assign rel    = (acc0 & m0_last) | (acc1 & m1_last) | tmo;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (m0_gnt) begin
      mem_we    = acc0 & m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (m1_gnt) begin
      mem_we    = acc1 & m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  // prio holds the last released owner; prio=0 lets m1 win the next tie.
  always_comb begin
    nxt      = state;
    prio_nxt = prio;
    case (state)
      IDLE: begin
        if (m0_req && m1_req) nxt = prio ? OWN0 : OWN1;
        else if (m0_req)      nxt = OWN0;
        else if (m1_req)      nxt = OWN1;
      end
      OWN0: if (rel) begin
        prio_nxt = 1'b0;
        nxt      = m1_req ? OWN1 : IDLE;
      end
      OWN1: if (rel) begin
        prio_nxt = 1'b1;
        nxt      = m0_req ? OWN0 : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= IDLE;
      prio      <= 1'b0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state     <= nxt;
      prio      <= prio_nxt;
      m0_gnt    <= (nxt == OWN0);
      m1_gnt    <= (nxt == OWN1);
      m0_rvalid <= acc0 & ~m0_we;
      m1_rvalid <= acc1 & ~m1_we;
      if (m0_rvalid) rdata0_q <= mem_rdata;
      if (m1_rvalid) rdata1_q <= mem_rdata;
    end
  end

  // RAM data arrives the cycle after the read beat; the held copy covers the other cycles.
  assign m0_rdata = m0_rvalid ? mem_rdata : rdata0_q;
  assign m1_rdata = m1_rvalid ? mem_rdata : rdata1_q;

`ifdef NLMS_ARB_TIMEOUT_EN
  localparam int CNT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  logic [CNT_W-1:0] tmo_cnt;

  assign tmo     = (state != IDLE) && !mem_en && (tmo_cnt == CNT_W'(TMO_CYC - 1));
  assign arb_err = tmo;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                     tmo_cnt <= '0;
    else if (mem_en || nxt != state)  tmo_cnt <= '0;
    else if (state != IDLE)           tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  logic unused_tmo;

  assign tmo        = 1'b0;
  assign arb_err    = 1'b0;
  assign unused_tmo = (TMO_CYC != 0);
`endif

endmodule

// File: tb/tb_nlms_mem_arbiter.sv
// Directed self-checking bench for nlms_mem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_nlms_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic          m0_req, m0_we, m0_last, m1_req, m1_we, m1_last;
  logic [AW-1:0] m0_addr, m1_addr, mem_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, mem_wdata, mem_rdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_en, mem_we, arb_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  nlms_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(64)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .m0_req(m0_req), .m0_we(m0_we), .m0_last(m0_last), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_last(m1_last), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .arb_err(arb_err)
  );

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    m0_req = 0; m0_we = 0; m0_last = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_last = 0; m1_addr = '0; m1_wdata = '0;
    mem_rdata = '0;
    @(negedge ACLK);
    checks++;
    if (m0_gnt !== 0 || m1_gnt !== 0 || mem_en !== 0 || mem_we !== 0 || arb_err !== 0) begin
      errors++; $display("FAIL reset_ctl: gnt=%b%b en=%b we=%b err=%b exp all 0", m0_gnt, m1_gnt, mem_en, mem_we, arb_err);
    end
    checks++;
    if (mem_addr !== 0 || mem_wdata !== 0 || m0_rvalid !== 0 || m1_rvalid !== 0 || m0_rdata !== 0 || m1_rdata !== 0) begin
      errors++; $display("FAIL reset_data: addr=%h wd=%h rv=%b%b rd0=%h rd1=%h exp 0", mem_addr, mem_wdata, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
    end
    step();
    ARESETN = 1'b1;
  endtask

  task automatic test_write_read();
    m0_req = 1; m0_we = 1; m0_addr = 0; m0_wdata = 1; m0_last = 0;
    @(negedge ACLK);
    checks++;
    if (m0_gnt !== 0 || mem_en !== 0) begin
      errors++; $display("FAIL grant_latency: gnt=%b en=%b exp 0 0", m0_gnt, mem_en);
    end
    step();
    for (int i = 0; i < 8; i++) begin
      m0_addr = AW'(i); m0_wdata = DW'(i + 1); m0_last = (i == 7);
      @(negedge ACLK);
      checks++;
      if (m0_gnt !== 1 || mem_en !== 1 || mem_we !== 1 || mem_addr !== AW'(i) || mem_wdata !== DW'(i + 1)) begin
        errors++; $display("FAIL wr_beat%0d: gnt=%b en=%b we=%b addr=%0d wd=%0d exp 1 1 1 %0d %0d", i, m0_gnt, mem_en, mem_we, mem_addr, mem_wdata, i, i + 1);
      end
      step();
    end
    m0_req = 0; m0_last = 0;
    @(negedge ACLK);
    checks++;
    if (m0_gnt !== 0 || mem_en !== 0) begin
      errors++; $display("FAIL wr_release: gnt=%b en=%b exp 0 0", m0_gnt, mem_en);
    end
    step();
    m0_req = 1; m0_we = 0; m0_addr = 0;
    step();
    for (int i = 0; i < 8; i++) begin
      m0_addr = AW'(i); m0_last = (i == 7);
      @(negedge ACLK);
      checks++;
      if (mem_en !== 1 || mem_we !== 0 || mem_addr !== AW'(i)) begin
        errors++; $display("FAIL rd_beat%0d: en=%b we=%b addr=%0d exp 1 0 %0d", i, mem_en, mem_we, mem_addr, i);
      end
      if (i > 0) begin
        checks++;
        if (m0_rvalid !== 1 || m0_rdata !== DW'(i)) begin
          errors++; $display("FAIL rd_data%0d: rvalid=%b rdata=%0d exp 1 %0d", i - 1, m0_rvalid, m0_rdata, i);
        end
      end
      step();
    end
    m0_req = 0; m0_last = 0;
    @(negedge ACLK);
    checks++;
    if (m0_rvalid !== 1 || m0_rdata !== 8 || m1_rvalid !== 0) begin
      errors++; $display("FAIL rd_data7: rvalid=%b rdata=%0d m1_rvalid=%b exp 1 8 0", m0_rvalid, m0_rdata, m1_rvalid);
    end
    step();
    @(negedge ACLK);
    checks++;
    if (m0_rvalid !== 0 || m0_rdata !== 8) begin
      errors++; $display("FAIL rd_hold: rvalid=%b rdata=%0d exp 0 8", m0_rvalid, m0_rdata);
    end
    step();
  endtask

  task automatic test_tie();
    ARESETN = 1'b0; #2; ARESETN = 1'b1;
    m0_req = 1; m0_we = 1; m0_addr = 50;  m0_wdata = 32'hA5;  m0_last = 1;
    m1_req = 1; m1_we = 1; m1_addr = 100; m1_wdata = 32'h100; m1_last = 0;
    @(negedge ACLK);
    checks++;
    if (m0_gnt !== 0 || m1_gnt !== 0) begin
      errors++; $display("FAIL tie_idle: gnt=%b%b exp 00", m0_gnt, m1_gnt);
    end
    step();
    @(negedge ACLK);
    checks++;
    if (m1_gnt !== 1 || m0_gnt !== 0 || mem_addr !== 100 || mem_wdata !== 32'h100) begin
      errors++; $display("FAIL tie_m1_first: gnt0=%b gnt1=%b addr=%0d wd=%h exp 0 1 100 100", m0_gnt, m1_gnt, mem_addr, mem_wdata);
    end
    step();
    m1_addr = 101; m1_wdata = 32'h101; m1_last = 1;
    @(negedge ACLK);
    checks++;
    if (m1_gnt !== 1 || mem_en !== 1 || mem_addr !== 101) begin
      errors++; $display("FAIL tie_m1_last: gnt1=%b en=%b addr=%0d exp 1 1 101", m1_gnt, mem_en, mem_addr);
    end
    step();
    m1_req = 0; m1_last = 0;
    @(negedge ACLK);
    checks++;
    if (m0_gnt !== 1 || m1_gnt !== 0 || mem_en !== 1 || mem_addr !== 50 || mem_wdata !== 32'hA5) begin
      errors++; $display("FAIL tie_handover: gnt0=%b gnt1=%b en=%b addr=%0d wd=%h exp 1 0 1 50 a5", m0_gnt, m1_gnt, mem_en, mem_addr, mem_wdata);
    end
    step();
    m0_req = 0; m0_last = 0;
    @(negedge ACLK);
    checks++;
    if (m0_gnt !== 0 || m1_gnt !== 0) begin
      errors++; $display("FAIL tie_idle_after: gnt=%b%b exp 00", m0_gnt, m1_gnt);
    end
    step();
  endtask

  task automatic test_hold();
    m1_req = 1; m1_we = 1; m1_addr = 200; m1_wdata = 32'h200; m1_last = 0;
    step();
    for (int b = 0; b < 2; b++) begin
      m1_addr = AW'(200 + b);
      @(negedge ACLK);
      checks++;
      if (m1_gnt !== 1 || mem_en !== 1 || mem_addr !== AW'(200 + b)) begin
        errors++; $display("FAIL hold_beat%0d: gnt1=%b en=%b addr=%0d exp 1 1 %0d", b, m1_gnt, mem_en, mem_addr, 200 + b);
      end
      step();
    end
    m1_req = 0;
    m0_req = 1; m0_we = 0; m0_addr = 3; m0_last = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      checks++;
      if (m1_gnt !== 1 || m0_gnt !== 0 || mem_en !== 0) begin
        errors++; $display("FAIL hold_gap%0d: gnt1=%b gnt0=%b en=%b exp 1 0 0", c, m1_gnt, m0_gnt, mem_en);
      end
      step();
    end
    m1_req = 1;
    for (int b = 2; b < 4; b++) begin
      m1_addr = AW'(200 + b); m1_last = (b == 3);
      @(negedge ACLK);
      checks++;
      if (m1_gnt !== 1 || m0_gnt !== 0 || mem_en !== 1 || mem_addr !== AW'(200 + b)) begin
        errors++; $display("FAIL hold_beat%0d: gnt1=%b gnt0=%b en=%b addr=%0d exp 1 0 1 %0d", b, m1_gnt, m0_gnt, mem_en, mem_addr, 200 + b);
      end
      step();
    end
    m1_req = 0; m1_last = 0;
    @(negedge ACLK);
    checks++;
    if (m0_gnt !== 1 || mem_en !== 1 || mem_we !== 0 || mem_addr !== 3) begin
      errors++; $display("FAIL hold_m0_grant: gnt0=%b en=%b we=%b addr=%0d exp 1 1 0 3", m0_gnt, mem_en, mem_we, mem_addr);
    end
    step();
    m0_req = 0; m0_last = 0;
    @(negedge ACLK);
    checks++;
    if (m0_rvalid !== 1 || m0_rdata !== 4 || m0_gnt !== 0 || m1_rvalid !== 0) begin
      errors++; $display("FAIL last_read_return: rvalid=%b rdata=%0d gnt0=%b m1_rvalid=%b exp 1 4 0 0", m0_rvalid, m0_rdata, m0_gnt, m1_rvalid);
    end
    step();
  endtask

  task automatic test_reset_mid();
    m0_req = 1; m0_we = 0; m0_addr = 0; m0_last = 0;
    step();
    for (int i = 0; i < 3; i++) begin
      m0_addr = AW'(i);
      @(negedge ACLK);
      checks++;
      if (mem_en !== 1 || mem_addr !== AW'(i)) begin
        errors++; $display("FAIL rst_beat%0d: en=%b addr=%0d exp 1 %0d", i, mem_en, mem_addr, i);
      end
      if (i < 2) step();
    end
    #1 ARESETN = 1'b0;
    #1;
    checks++;
    if (m0_gnt !== 0 || mem_en !== 0 || mem_addr !== 0 || m0_rvalid !== 0 || m0_rdata !== 0 || arb_err !== 0) begin
      errors++; $display("FAIL rst_async: gnt=%b en=%b addr=%0d rv=%b rd=%0d err=%b exp all 0", m0_gnt, mem_en, mem_addr, m0_rvalid, m0_rdata, arb_err);
    end
    m0_req = 0;
    step();
    ARESETN = 1'b1;
    @(negedge ACLK);
    checks++;
    if (m0_rvalid !== 0 || m0_gnt !== 0 || mem_en !== 0) begin
      errors++; $display("FAIL rst_discard: rvalid=%b gnt=%b en=%b exp 0 0 0", m0_rvalid, m0_gnt, mem_en);
    end
    step();
    m0_req = 1; m0_addr = 4; m0_last = 1;
    @(negedge ACLK);
    checks++;
    if (m0_gnt !== 0) begin
      errors++; $display("FAIL rst_regrant_lat: gnt=%b exp 0", m0_gnt);
    end
    step();
    @(negedge ACLK);
    checks++;
    if (m0_gnt !== 1 || mem_en !== 1 || mem_addr !== 4) begin
      errors++; $display("FAIL rst_regrant: gnt=%b en=%b addr=%0d exp 1 1 4", m0_gnt, mem_en, mem_addr);
    end
    step();
    m0_req = 0; m0_last = 0;
    @(negedge ACLK);
    checks++;
    if (m0_rvalid !== 1 || m0_rdata !== 5) begin
      errors++; $display("FAIL rst_regrant_data: rvalid=%b rdata=%0d exp 1 5", m0_rvalid, m0_rdata);
    end
    step();
  endtask

  task automatic test_timeout();
    m0_req = 1; m0_we = 1; m0_addr = 300; m0_wdata = 32'h300; m0_last = 0;
    step();
    @(negedge ACLK);
    checks++;
    if (m0_gnt !== 1 || mem_en !== 1) begin
      errors++; $display("FAIL tmo_own: gnt0=%b en=%b exp 1 1", m0_gnt, mem_en);
    end
    step();
    m0_req = 0;
    m1_req = 1; m1_we = 1; m1_addr = 301; m1_wdata = 32'h301; m1_last = 1;
`ifdef NLMS_ARB_TIMEOUT_EN
    for (int k = 1; k <= 64; k++) begin
      @(negedge ACLK);
      checks++;
      if (m0_gnt !== 1 || m1_gnt !== 0 || arb_err !== (k == 64)) begin
        errors++; $display("FAIL tmo_stall%0d: gnt0=%b gnt1=%b err=%b exp 1 0 %0d", k, m0_gnt, m1_gnt, arb_err, k == 64);
      end
      step();
    end
    @(negedge ACLK);
    checks++;
    if (m1_gnt !== 1 || m0_gnt !== 0 || arb_err !== 0 || mem_en !== 1) begin
      errors++; $display("FAIL tmo_release: gnt1=%b gnt0=%b err=%b en=%b exp 1 0 0 1", m1_gnt, m0_gnt, arb_err, mem_en);
    end
    step();
    m1_req = 0; m1_last = 0;
`else
    for (int k = 1; k <= 70; k++) begin
      @(negedge ACLK);
      checks++;
      if (m0_gnt !== 1 || m1_gnt !== 0 || arb_err !== 0 || mem_en !== 0) begin
        errors++; $display("FAIL notmo_stall%0d: gnt0=%b gnt1=%b err=%b en=%b exp 1 0 0 0", k, m0_gnt, m1_gnt, arb_err, mem_en);
      end
      step();
    end
    m0_req = 1; m0_addr = 302; m0_last = 1;
    @(negedge ACLK);
    checks++;
    if (mem_en !== 1 || mem_addr !== 302 || m0_gnt !== 1) begin
      errors++; $display("FAIL notmo_last: en=%b addr=%0d gnt0=%b exp 1 302 1", mem_en, mem_addr, m0_gnt);
    end
    step();
    m0_req = 0; m0_last = 0;
    @(negedge ACLK);
    checks++;
    if (m1_gnt !== 1 || m0_gnt !== 0 || mem_addr !== 301) begin
      errors++; $display("FAIL notmo_handover: gnt1=%b gnt0=%b addr=%0d exp 1 0 301", m1_gnt, m0_gnt, mem_addr);
    end
    step();
    m1_req = 0; m1_last = 0;
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_tie();
    test_hold();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nlms_mem_arbiter.md
NLMS_MEM_ARBITER -- requirements
Module: nlms_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word address width of the shared memory.
REQ-002 SHALL have parameter DATA_W, default 32, data width of the shared memory.
REQ-003 SHALL have parameter TMO_CYC, default 64, watchdog limit in cycles (used only with NLMS_ARB_TIMEOUT_EN).
REQ-004 SHALL have port ACLK  in  1  single clock, rising edge.
REQ-005 SHALL have port ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports m0_req/m1_req  in  1  requester wants a beat (m0 = AXI slave side, m1 = filter core).
REQ-007 SHALL have ports m0_we/m1_we  in  1  beat is a write (1) or a read (0).
REQ-008 SHALL have ports m0_last/m1_last  in  1  beat is the final beat of the burst.
REQ-009 SHALL have ports m0_addr/m1_addr  in  ADDR_W  and m0_wdata/m1_wdata  in  DATA_W  beat address and write data.
REQ-010 SHALL have ports m0_gnt/m1_gnt  out  1  requester owns the memory.
REQ-011 SHALL have ports m0_rvalid/m1_rvalid  out  1  and m0_rdata/m1_rdata  out  DATA_W  read return.
REQ-012 SHALL have ports mem_en, mem_we  out  1;  mem_addr  out  ADDR_W;  mem_wdata  out  DATA_W;  mem_rdata  in  DATA_W  (single-port RAM, 1-cycle read latency).
REQ-013 SHALL have port arb_err  out  1  one-cycle pulse on forced release.

Function
REQ-014 SHALL implement FSM states IDLE, OWN0, OWN1; mN_gnt SHALL be a registered decode of state (OWN0 -> m0_gnt=1, OWN1 -> m1_gnt=1).
REQ-015 A beat SHALL be accepted in a cycle where mN_req=1 and mN_gnt=1; mem_en=1 exactly in that cycle, with mem_we/addr/wdata driven combinationally from the owner.
REQ-016 IDLE: single request -> corresponding OWN state next cycle; both requesting -> the requester not served last (prio bit, reset value 0 so m1 wins the first tie) .
REQ-017 OWNx SHALL hold ownership until an accepted beat with mx_last=1; mx_req deasserting mid-burst SHALL NOT release ownership.
REQ-018 On accepted last beat: other requester pending -> switch directly to its OWN state next cycle (no idle gap); else -> IDLE; prio bit updated to the released owner.
REQ-019 Read return: mN_rvalid=1 exactly one cycle after an accepted read beat from N, mN_rdata=mem_rdata in that cycle; rdata of the non-returning requester SHALL hold its last value.
REQ-020 A read accepted as a last beat SHALL still return rvalid to its issuer even though ownership changes that cycle.
REQ-021 Throughput SHALL be one beat per cycle while the owner keeps req asserted; worst-case grant latency from IDLE is 1 cycle.
REQ-022 mem_en SHALL never be 1 while no gnt is asserted; m0_gnt and m1_gnt SHALL never both be 1.

Reset
REQ-023 ARESETN low SHALL asynchronously force state IDLE, prio=0, m0_gnt=m1_gnt=0, mem_en=mem_we=0, mem_addr=mem_wdata=0, rvalid=0, rdata=0, arb_err=0, watchdog counter=0.
REQ-024 Reset mid-burst SHALL abort the burst with no further mem_en; a pending read return SHALL be discarded (no rvalid after reset).

Configuration
REQ-025 With NLMS_ARB_TIMEOUT_EN defined: a counter SHALL clear on every accepted beat and on ownership change, increment each OWN cycle without an accepted beat; on reaching TMO_CYC the owner SHALL be released as if a last beat occurred and arb_err pulses for 1 cycle.
REQ-026 Without NLMS_ARB_TIMEOUT_EN: no counter is built, ownership is held indefinitely, arb_err is tied 0, TMO_CYC is ignored.

Verification
REQ-027 m0 writes 8 beats (addr 0..7, data 1..8, last on beat 8), m0 reads the same 8 -> readback 1..8, rvalid one cycle after each read beat.
REQ-028 m0_req and m1_req rise in the same cycle after reset -> m1_gnt first; after m1 last, m0_gnt next cycle with no idle cycle between.
REQ-029 m1 owns a 4-beat burst and drops req after beat 2 for 5 cycles while m0 requests -> m1 keeps gnt, m0_gnt=0 until m1 last accepted.
REQ-030 ARESETN pulsed low during beat 3 of an 8-beat read -> all outputs 0 immediately, no rvalid afterwards, next request granted 1 cycle after request.
REQ-031 NLMS_ARB_TIMEOUT_EN, TMO_CYC=64: owner stalls without last -> release and arb_err=1 at stall cycle 64, pending m1 granted next cycle; without macro -> no release, arb_err stays 0.
